vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Single-port framebuffer arbiter between the VGA scanout fetcher and a host pixel-write/read port. Sits between the pixel clock domain logic (scanout prefetch driven by the sync generator's hpos/vpos) and one external synchronous single-port RAM holding 3-bit RGB pixels. Scanout has priority; the host is served in idle slots and, optionally, by a guaranteed fairness slot.

## Interface
Parameters:
- ADDR_W, 17, framebuffer word address width
- DATA_W, 3, pixel width (RGB, one bit per channel)
- BURST_MAX, 8, max consecutive scan grants while host waits before a forced host slot (FB_ARB_FAIR_EN only); range 1..255

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- scan_req  in  1  scanout read request
- scan_addr  in  ADDR_W  scanout read address
- scan_gnt  out  1  scan request accepted this cycle
- scan_rvalid  out  1  scan read data valid
- scan_rdata  out  DATA_W  scan read data
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid (never for writes)
- host_rdata  out  DATA_W  host read data
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- One RAM access per cycle. Requesters hold req/addr/data stable until gnt; gnt is combinational from req and current state, and at most one gnt is high per cycle.
- FSM states: ARB_IDLE (no grant last cycle), ARB_SCAN (scan granted last cycle), ARB_HOST (host granted last cycle), ARB_FORCE (forced host slot pending).
- Grant rule: scan_req wins unless state is ARB_FORCE and host_req is high; otherwise host wins when scan_req low.
- Streak counter: increments on each scan grant while host_req high; clears on any host grant or when host_req low. Reaching BURST_MAX moves FSM to ARB_FORCE; next cycle with host_req high grants host, then returns to ARB_HOST. If host drops req in ARB_FORCE, return to ARB_IDLE.
- Granted access registered onto mem_* next cycle; mem_en low when no grant. mem_wdata holds last value when idle.
- Read tag register (2 bits: scan read, host read) follows each access; rdata is mem_rdata routed to the tagged requester; other requester's rdata holds its last value.
- Host writes never raise host_rvalid.

## Timing
- Grant in cycle N; mem_* driven in N+1; rvalid + rdata in N+2. Fixed latency 2, fully pipelined, one access per cycle sustained.
- Reset (async assert, sync release): all outputs 0, FSM ARB_IDLE, streak 0, tags cleared. Reset mid-transaction discards in-flight reads: no rvalid after release.
- Simultaneous req: scan granted (except ARB_FORCE). Host worst-case wait with FB_ARB_FAIR_EN: BURST_MAX+1 cycles.
- Streak counter saturates at BURST_MAX; never wraps.

## Configuration
- FB_ARB_FAIR_EN defined: streak counter and ARB_FORCE present, host wait bounded as above.
- Undefined: strict scan priority; counter and ARB_FORCE removed; host served only when scan_req low (may starve during active video, serviced in blanking). BURST_MAX ignored.

## Structure
- Package vga_pkg: state encoding enum for ARB_* states, default ADDR_W/DATA_W constants, read-tag encoding.
- One sub-module: vga_fb_arb_fsm (grant decision, state, streak counter); top holds mem_* pipeline registers and read-data routing.

## Test plan
- Host write addr 0x00010 data 3'b101 with scan idle -> host_gnt cycle N, mem_we=1 addr 0x00010 at N+1, no host_rvalid; subsequent host read returns 3'b101 at grant+2.
- Scan reads back-to-back 0..639 with host idle -> scan_gnt every cycle, scan_rvalid continuous from grant+2, data matches RAM model in order.
- Both req every cycle, FB_ARB_FAIR_EN, BURST_MAX=8 -> pattern 8 scan grants, 1 host grant, repeating; never two gnt in one cycle.
- Same stimulus, macro undefined -> host_gnt never high while scan_req high; granted on first scan_req-low cycle.
- Reset asserted one cycle after scan grant -> outputs 0 immediately, no scan_rvalid after release, first post-reset grant behaves as from ARB_IDLE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types for the VGA framebuffer arbiter: arbitration states, default
// widths and the read-tag bit layout.
package vga_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_SCAN  = 2'd1,
    ARB_HOST  = 2'd2,
    ARB_FORCE = 2'd3
  } arb_state_e;

  // Read tag: bit 1 marks a scan read, bit 0 a host read in the memory stage.
  localparam int TAG_SCAN = 1;
  localparam int TAG_HOST = 0;
  typedef logic [1:0] rd_tag_t;

  function automatic rd_tag_t make_tag(input logic scan_rd, input logic host_rd);
    return {scan_rd, host_rd};
  endfunction

endpackage

// File: rtl/vga_fb_arb_fsm.sv
// Grant decision and arbitration state for the framebuffer arbiter.
// Define FB_ARB_FAIR_EN to add the scan streak counter and the forced host slot.
module vga_fb_arb_fsm
  import vga_pkg::*;
#(
  parameter int BURST_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_req,
  input  logic host_req,
  output logic scan_gnt,
  output logic host_gnt,
  output logic scan_acc,
  output logic host_acc
);

  arb_state_e state_q, state_d;
  logic       force_host;

`ifdef FB_ARB_FAIR_EN
  localparam int unsigned STREAK_W = $clog2(BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(BURST_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;

  assign force_host = (state_q == ARB_FORCE) && host_req;
`else
  assign force_host = 1'b0;
`endif

  // Grants are gated by reset so every output reads 0 while reset is held.
  assign host_gnt = reset && host_req && (!scan_req || force_host);
  assign scan_gnt = reset && scan_req && !force_host;

  always_comb begin
    if (host_gnt) begin
      state_d = ARB_HOST;
    end else if (scan_gnt) begin
      state_d = ARB_SCAN;
    end else begin
      state_d = ARB_IDLE;
    end
`ifdef FB_ARB_FAIR_EN
    streak_d = streak_q;
    if (host_gnt || !host_req) begin
      streak_d = '0;
    end else if (scan_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
    if (scan_gnt && host_req && (streak_d == STREAK_MAX)) begin
      state_d = ARB_FORCE;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
`ifdef FB_ARB_FAIR_EN
      streak_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef FB_ARB_FAIR_EN
      streak_q <= streak_d;
`endif
    end
  end

  // ARB_FORCE is only ever entered on a scan grant, so it also marks a scan access.
  assign scan_acc = (state_q == ARB_SCAN) || (state_q == ARB_FORCE);
  assign host_acc = (state_q == ARB_HOST);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout has priority, host uses idle slots.
// Define FB_ARB_FAIR_EN to bound host wait to BURST_MAX+1 cycles.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_gnt,
  output logic              scan_rvalid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              scan_acc, host_acc;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  rd_tag_t           tag_q, tag_d;
  logic [DATA_W-1:0] scan_rdata_q, host_rdata_q;

  vga_fb_arb_fsm #(
    .BURST_MAX(BURST_MAX)
  ) u_fsm (
    .clk     (clk),
    .reset   (reset),
    .scan_req(scan_req),
    .host_req(host_req),
    .scan_gnt(scan_gnt),
    .host_gnt(host_gnt),
    .scan_acc(scan_acc),
    .host_acc(host_acc)
  );

  assign tag_d = make_tag(scan_acc, host_acc && !mem_we_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tag_q        <= '0;
      scan_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      mem_we_q <= host_gnt && host_we;
      if (scan_gnt) begin
        mem_addr_q <= scan_addr;
      end else if (host_gnt) begin
        mem_addr_q <= host_addr;
      end
      if (host_gnt && host_we) begin
        mem_wdata_q <= host_wdata;
      end
      tag_q <= tag_d;
      if (tag_q[TAG_SCAN]) begin
        scan_rdata_q <= mem_rdata;
      end
      if (tag_q[TAG_HOST]) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = scan_acc || host_acc;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // RAM data arrives the cycle after the access; route it straight through, hold otherwise.
  assign scan_rvalid = tag_q[TAG_SCAN];
  assign host_rvalid = tag_q[TAG_HOST];
  assign scan_rdata  = tag_q[TAG_SCAN] ? mem_rdata : scan_rdata_q;
  assign host_rdata  = tag_q[TAG_HOST] ? mem_rdata : host_rdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a RAM model and a per-cycle
// reference model; follows FB_ARB_FAIR_EN when it is defined for the build.
module tb_vga_fb_arbiter;

  localparam int AW = 17;
  localparam int DW = 3;
  localparam int BM = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          scan_gnt, scan_rvalid;
  logic [DW-1:0] scan_rdata;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // External synchronous single-port RAM
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state
  typedef struct {
    int            due;
    bit            is_scan;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rq[$];
  int            total = 0, bad = 0, cyc = 0;
  int            waited = 0;
  int            hg_seen = 0, sg_seen = 0;
  logic          e_sg, e_hg;
  logic          x_en = 1'b0, x_we = 1'b0;
  logic [AW-1:0] x_addr = '0;
  logic [DW-1:0] x_wdata = '0;
  logic [DW-1:0] last_s = '0, last_h = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    waited  = 0;
    x_en    = 1'b0;
    x_we    = 1'b0;
    x_addr  = '0;
    x_wdata = '0;
    last_s  = '0;
    last_h  = '0;
  endtask

  // One clock cycle: check everything at the falling edge, then advance the model.
  task automatic cycle();
    logic          ev_s, ev_h;
    logic [DW-1:0] ed_s, ed_h;
    rd_t           r;
    @(negedge clk);
`ifdef FB_ARB_FAIR_EN
    e_hg = host_req && (!scan_req || waited >= BM);
    e_sg = scan_req && !(host_req && waited >= BM);
`else
    e_hg = host_req && !scan_req;
    e_sg = scan_req;
`endif
    chk("scan_gnt", scan_gnt, e_sg);
    chk("host_gnt", host_gnt, e_hg);
    chk("single_gnt", scan_gnt & host_gnt, 0);
    if (scan_gnt) sg_seen++;
    if (host_gnt) hg_seen++;
    chk("mem_en", mem_en, x_en);
    chk("mem_we", mem_we, x_we);
    if (x_en) chk("mem_addr", mem_addr, x_addr);
    chk("mem_wdata", mem_wdata, x_wdata);
    ev_s = 1'b0; ev_h = 1'b0; ed_s = last_s; ed_h = last_h;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.is_scan) begin ev_s = 1'b1; ed_s = r.data; end
      else           begin ev_h = 1'b1; ed_h = r.data; end
    end
    chk("scan_rvalid", scan_rvalid, ev_s);
    chk("scan_rdata", scan_rdata, ed_s);
    chk("host_rvalid", host_rvalid, ev_h);
    chk("host_rdata", host_rdata, ed_h);
    last_s = ed_s;
    last_h = ed_h;
    // Access granted now appears on the RAM port next cycle, data the cycle after.
    x_en = e_sg || e_hg;
    x_we = e_hg && host_we;
    if (e_sg)      x_addr = scan_addr;
    else if (e_hg) x_addr = host_addr;
    if (e_hg && host_we) x_wdata = host_wdata;
    if (e_sg) rq.push_back('{due: cyc + 2, is_scan: 1'b1, data: ref_mem[scan_addr]});
    if (e_hg && !host_we) rq.push_back('{due: cyc + 2, is_scan: 1'b0, data: ref_mem[host_addr]});
    if (e_hg && host_we) ref_mem[host_addr] = host_wdata;
    if (!host_req || e_hg) waited = 0;
    else if (e_sg && waited < BM) waited++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_scan_gnt"}, scan_gnt, 0);
    chk({tag, "_host_gnt"}, host_gnt, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_scan_rvalid"}, scan_rvalid, 0);
    chk({tag, "_scan_rdata"}, scan_rdata, 0);
    chk({tag, "_host_rvalid"}, host_rvalid, 0);
    chk({tag, "_host_rdata"}, host_rdata, 0);
  endtask

  initial begin
    int hg0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset with both requests high: every output must be 0
    reset = 1'b1;
    #1 reset = 1'b0;
    scan_req = 1'b1;
    host_req = 1'b1;
    #2;
    check_all_zero("reset");
    scan_req = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("tb: reset released");

    // Host write then read back with scan idle
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00010; host_wdata = 3'b101;
    cycle();
    host_req = 1'b0;
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 17'h00010);
    cycle();
    host_req = 1'b1; host_we = 1'b0;
    cycle();
    host_req = 1'b0;
    cycle();
    chk("rd_rvalid", host_rvalid, 1);
    chk("rd_rdata", host_rdata, 3'b101);
    cycle();
    $display("tb: host write/read 0x00010 done, rdata=%0b", host_rdata);

    // Back-to-back scanout line
    sg_seen = 0;
    scan_req = 1'b1;
    for (int i = 0; i < 640; i++) begin
      scan_addr = AW'(i);
      cycle();
    end
    scan_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("scan_line_grants", sg_seen, 640);
    $display("tb: scan line 0..639 done, grants=%0d", sg_seen);

    // Both requesting every cycle, then scan drops for one cycle
    hg_seen = 0;
    scan_req = 1'b1; scan_addr = 17'h00100;
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00010;
    for (int i = 0; i < 45; i++) cycle();
`ifdef FB_ARB_FAIR_EN
    chk("contend_host_grants", hg_seen, 5);
`else
    chk("contend_host_grants", hg_seen, 0);
`endif
    hg0 = hg_seen;
    scan_req = 1'b0;
    cycle();
    chk("blank_host_grant", hg_seen - hg0, 1);
    host_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    $display("tb: contention done, host grants=%0d", hg_seen);

    // Random traffic; requesters hold their request until granted
    for (int i = 0; i < 2500; i++) begin
      if (!scan_req || e_sg) begin
        scan_req  = ($urandom_range(0, 3) != 0);
        scan_addr = AW'($urandom_range(0, 63));
      end
      if (!host_req || e_hg) begin
        host_req   = ($urandom_range(0, 2) == 0);
        host_we    = $urandom_range(0, 1) == 1;
        host_addr  = AW'($urandom_range(0, 31));
        host_wdata = DW'($urandom);
      end
      cycle();
    end
    scan_req = 1'b0;
    host_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    $display("tb: random traffic done");

    // Reset one cycle after a scan grant: in-flight read is discarded
    scan_req = 1'b1; scan_addr = 17'h00005;
    cycle();
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    scan_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle();
    scan_req = 1'b1; scan_addr = 17'h00007;
    cycle();
    scan_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("post_reset_queue_drained", rq.size(), 0);
    $display("tb: mid-transaction reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
